// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the serial pattern scan controller.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PAT_W_MAX = 16;
    // Fill counter must be able to hold the value PAT_W_MAX itself.
    localparam int FILL_W    = $clog2(PAT_W_MAX + 1);

endpackage

// File: rtl/pattern_window.sv
// Bit-serial detection window: PAT_W shift register, fill counter and pattern
// comparator; hit is combinational on the bit being shifted this cycle.
module pattern_window
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window_q, window_d, win_shift_s;
    logic [FILL_W-1:0] fill_q, fill_d, fill_shift_s;

    // Shift/compare: match is judged on the post-shift window and fill.
    always_comb begin
        win_shift_s  = (window_q << 1'b1) | PAT_W'(bit_in);
        fill_shift_s = (fill_q >= FILL_FULL) ? FILL_FULL : (fill_q + FILL_W'(1));
        window_d     = window_q;
        fill_d       = fill_q;
        hit          = 1'b0;
        if (clr) begin
            window_d = {PAT_W{1'b0}};
            fill_d   = {FILL_W{1'b0}};
        end else if (bit_en) begin
            window_d = win_shift_s;
            fill_d   = fill_shift_s;
            if ((fill_shift_s == FILL_FULL) && (win_shift_s == pattern)) begin
                hit = 1'b1;
                // Non-overlapping mode demands PAT_W fresh bits before the next hit.
                if (!overlap) begin
                    fill_d = {FILL_W{1'b0}};
                end else begin
                    fill_d = fill_shift_s;
                end
            end else begin
                hit = 1'b0;
            end
        end else begin
            window_d = window_q;
        end
    end

    // Window and fill state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            window_q <= {PAT_W{1'b0}};
            fill_q   <= {FILL_W{1'b0}};
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencing controller: accepts words over valid/ready, shifts them
// MSB-first through pattern_window, and counts/report matches per scan.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              count_sat,
    output logic              done
);

    localparam int               IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [PAT_W-1:0]    pattern_q, pattern_d;
    logic                overlap_q, overlap_d;
    logic [CNT_W-1:0]    match_count_q, match_count_d;
    logic                count_sat_q, count_sat_d;
    logic                match_pulse_q, match_pulse_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                done_q, done_d;
    logic                clr_s;
    logic                bit_en_s;
    logic                hit_s;

    pattern_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_s),
        .bit_en  (bit_en_s),
        .bit_in  (word_q[bit_idx_q]),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .hit     (hit_s)
    );

    // Next-state, datapath and match-counter logic.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        last_d        = last_q;
        bit_idx_d     = bit_idx_q;
        pattern_d     = pattern_q;
        overlap_d     = overlap_q;
        match_count_d = match_count_q;
        count_sat_d   = count_sat_q;
        clr_s         = 1'b0;
        bit_en_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pattern_d     = cfg_pattern;
                    overlap_d     = cfg_overlap;
                    match_count_d = {CNT_W{1'b0}};
                    count_sat_d   = 1'b0;
                    clr_s         = 1'b1;
                    state_d       = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // in_ready is high for the whole of LOAD, so in_valid alone completes the handshake.
                if (in_valid) begin
                    word_d    = in_data;
                    last_d    = in_last;
                    bit_idx_d = IDX_TOP;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                bit_en_s = 1'b1;
                if (bit_idx_q == {IDX_W{1'b0}}) begin
                    state_d = last_q ? ST_DONE : ST_LOAD;
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hit_s) begin
            if (match_count_q != CNT_MAX) begin
                match_count_d = match_count_q + CNT_W'(1);
            end else begin
                match_count_d = match_count_q;
            end
            if (match_count_d == CNT_MAX) begin
                count_sat_d = 1'b1;
            end else begin
                count_sat_d = count_sat_q;
            end
        end else begin
            match_count_d = match_count_d;
        end

        match_pulse_d = hit_s;
        busy_d        = (state_d != ST_IDLE);
        in_ready_d    = (state_d == ST_LOAD);
        done_d        = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            word_q        <= {DATA_W{1'b0}};
            last_q        <= 1'b0;
            bit_idx_q     <= {IDX_W{1'b0}};
            pattern_q     <= {PAT_W{1'b0}};
            overlap_q     <= 1'b0;
            match_count_q <= {CNT_W{1'b0}};
            count_sat_q   <= 1'b0;
            match_pulse_q <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            last_q        <= last_d;
            bit_idx_q     <= bit_idx_d;
            pattern_q     <= pattern_d;
            overlap_q     <= overlap_d;
            match_count_q <= match_count_d;
            count_sat_q   <= count_sat_d;
            match_pulse_q <= match_pulse_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign in_ready    = in_ready_q;
    assign done        = done_q;
    assign match_pulse = match_pulse_q;
    assign match_count = match_count_q;
    assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: table of scans, directed corner
// cases and random scans against a queue-based bit-stream model.
module tb_pattern_scan_ctrl;

    localparam int DW  = 8;
    localparam int PW  = 4;
    localparam int CW  = 8;
    localparam int CW2 = 2;

    logic          clk = 1'b0;
    logic          reset, start, cfg_overlap, in_valid, in_last;
    logic [PW-1:0] cfg_pattern;
    logic [DW-1:0] in_data;

    logic           busy, in_ready, match_pulse, count_sat, done;
    logic [CW-1:0]  match_count;
    logic           busy2, in_ready2, match_pulse2, count_sat2, done2;
    logic [CW2-1:0] match_count2;

    int checks = 0;
    int errors = 0;

    // Model state: bits seen since the scan start or the last non-overlap clear.
    logic          bq[$];
    int            nmatch;
    logic [DW-1:0] words[$];
    int            gaps[$];

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .busy(busy), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .match_pulse(match_pulse), .match_count(match_count),
        .count_sat(count_sat), .done(done)
    );

    pattern_scan_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .busy(busy2), .in_valid(in_valid),
        .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .match_pulse(match_pulse2), .match_count(match_count2),
        .count_sat(count_sat2), .done(done2)
    );

    typedef struct {
        logic [PW-1:0] pat;
        logic          ov;
        int            nw;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        int            exp_cnt;
        int            exp_cnt2;
        logic          exp_sat2;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat_val(input int n, input int w);
        int m;
        m = (1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    task automatic check_outs(input string tag, input logic e_busy, input logic e_ready,
                              input logic e_pulse, input logic e_done);
        chk({tag, ".busy"},      int'(busy),        int'(e_busy));
        chk({tag, ".in_ready"},  int'(in_ready),    int'(e_ready));
        chk({tag, ".pulse"},     int'(match_pulse), int'(e_pulse));
        chk({tag, ".done"},      int'(done),        int'(e_done));
        chk({tag, ".count"},     int'(match_count), sat_val(nmatch, CW));
        chk({tag, ".sat"},       int'(count_sat),   int'(nmatch >= 255));
        chk({tag, ".busy2"},     int'(busy2),       int'(e_busy));
        chk({tag, ".in_ready2"}, int'(in_ready2),   int'(e_ready));
        chk({tag, ".pulse2"},    int'(match_pulse2), int'(e_pulse));
        chk({tag, ".done2"},     int'(done2),       int'(e_done));
        chk({tag, ".count2"},    int'(match_count2), sat_val(nmatch, CW2));
        chk({tag, ".sat2"},      int'(count_sat2),  int'(nmatch >= 3));
    endtask

    // Append one bit to the stream; a match is the last PW bits equal to the pattern.
    task automatic model_bit(input logic b, input logic [PW-1:0] pat, input logic ov,
                             output logic hit);
        logic [PW-1:0] w;
        hit = 1'b0;
        bq.push_back(b);
        if (bq.size() >= PW) begin
            for (int i = 0; i < PW; i++) w[i] = bq[bq.size() - 1 - i];
            if (w == pat) begin
                hit = 1'b1;
                nmatch++;
                if (!ov) bq.delete();
            end
        end
    endtask

    task automatic run_scan(input string tag, input logic [PW-1:0] pat, input logic ov,
                            input bit poke, output int npulse);
        logic exp_p;
        int   nw;
        nw     = words.size();
        npulse = 0;
        exp_p  = 1'b0;
        bq.delete();
        nmatch = 0;
        cfg_pattern = pat;
        cfg_overlap = ov;
        start       = 1'b1;
        tick();
        start = 1'b0;
        // Configuration changes while busy must have no effect.
        cfg_pattern = PW'($urandom);
        cfg_overlap = 1'($urandom);
        for (int w = 0; w < nw; w++) begin
            for (int c = 0; c <= gaps[w]; c++) begin
                check_outs({tag, ".load"}, 1'b1, 1'b1, exp_p, 1'b0);
                if (match_pulse) npulse++;
                exp_p    = 1'b0;
                in_valid = (c == gaps[w]);
                in_data  = (c == gaps[w]) ? words[w] : DW'($urandom);
                in_last  = (c == gaps[w]) && (w == nw - 1);
                tick();
            end
            for (int k = DW - 1; k >= 0; k--) begin
                check_outs({tag, ".shift"}, 1'b1, 1'b0, exp_p, 1'b0);
                if (match_pulse) npulse++;
                model_bit(words[w][k], pat, ov, exp_p);
                in_valid = poke ? 1'($urandom) : 1'b1;
                in_data  = DW'($urandom);
                in_last  = 1'($urandom);
                start    = poke ? 1'($urandom) : 1'b0;
                tick();
            end
            start = 1'b0;
        end
        in_valid = 1'b0;
        check_outs({tag, ".done"}, 1'b1, 1'b0, exp_p, 1'b1);
        if (match_pulse) npulse++;
        tick();
        check_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int npulse;

        tbl[0] = '{4'b1010, 1'b1, 1, 8'hAA, 8'h00, 3,  3, 1'b1};
        tbl[1] = '{4'b1010, 1'b0, 1, 8'hAA, 8'h00, 2,  2, 1'b0};
        tbl[2] = '{4'b1010, 1'b1, 2, 8'h05, 8'h00, 1,  1, 1'b0};
        tbl[3] = '{4'b0000, 1'b1, 1, 8'h00, 8'h00, 5,  3, 1'b1};
        tbl[4] = '{4'b0000, 1'b0, 1, 8'h00, 8'h00, 2,  2, 1'b0};
        tbl[5] = '{4'b1111, 1'b1, 2, 8'hFF, 8'hFF, 13, 3, 1'b1};

        reset       = 1'b1;
        start       = 1'b0;
        cfg_pattern = 4'b0000;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        nmatch      = 0;
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Table of known scans with valid held high throughout.
        for (int t = 0; t < 6; t++) begin
            string tag;
            tag = $sformatf("tbl%0d", t);
            words.delete();
            gaps.delete();
            words.push_back(tbl[t].w0);
            gaps.push_back(0);
            if (tbl[t].nw > 1) begin
                words.push_back(tbl[t].w1);
                gaps.push_back(0);
            end
            run_scan(tag, tbl[t].pat, tbl[t].ov, 1'b0, npulse);
            chk({tag, ".pulses"},    npulse,              tbl[t].exp_cnt);
            chk({tag, ".final_cnt"}, int'(match_count),   tbl[t].exp_cnt);
            chk({tag, ".final_cnt2"}, int'(match_count2), tbl[t].exp_cnt2);
            chk({tag, ".final_sat2"}, int'(count_sat2),   int'(tbl[t].exp_sat2));
        end

        // Long stall in LOAD with start pokes during the scan.
        words.delete();
        gaps.delete();
        words.push_back(8'h5A);
        gaps.push_back(20);
        words.push_back(8'hA5);
        gaps.push_back(2);
        run_scan("stall", 4'b1010, 1'b1, 1'b1, npulse);
        chk("stall.pulses", npulse, nmatch);

        // Default-width counter saturation: 33 zero words give 261 overlapping matches.
        words.delete();
        gaps.delete();
        for (int i = 0; i < 33; i++) begin
            words.push_back(8'h00);
            gaps.push_back(0);
        end
        run_scan("sat8", 4'b0000, 1'b1, 1'b0, npulse);
        chk("sat8.pulses", npulse, 261);
        chk("sat8.count", int'(match_count), 255);
        chk("sat8.flag", int'(count_sat), 1);

        // Reset while shifting aborts the scan with nothing reported.
        cfg_pattern = 4'b1010;
        cfg_overlap = 1'b1;
        start       = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("abort.busy_before", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bq.delete();
        nmatch = 0;
        for (int i = 0; i < 12; i++) begin
            check_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        words.delete();
        gaps.delete();
        words.push_back(8'hAA);
        gaps.push_back(0);
        run_scan("after_abort", 4'b1010, 1'b1, 1'b0, npulse);
        chk("after_abort.pulses", npulse, 3);
        chk("after_abort.count", int'(match_count), 3);

        // Random scans against the model.
        for (int r = 0; r < 25; r++) begin
            int nw;
            logic [PW-1:0] pat;
            logic ov;
            string tag;
            tag = $sformatf("rnd%0d", r);
            words.delete();
            gaps.delete();
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) begin
                words.push_back(DW'($urandom));
                gaps.push_back($urandom_range(0, 3));
            end
            pat = PW'($urandom);
            ov  = 1'($urandom);
            run_scan(tag, pat, ov, 1'b1, npulse);
            chk({tag, ".pulses"}, npulse, nmatch);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
